pit_fib_port: RTL and testbench
===============================

PIT_FIB_PORT -- requirements
Module: pit_fib_port

Parameters
REQ-001 SHALL have QDEPTH, default 4: outgoing interest queue depth.
REQ-002 SHALL have PDEPTH, default 4: pending-interest table entries.
REQ-003 SHALL have PAYLOAD_BYTES, default 4: data bytes per accepted FIB return.

Interface
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  local PIT logic offers an outgoing interest.
REQ-007 req_prefix  in  64  interest prefix.
REQ-008 req_len  in  6  prefix length in bits, 0-63.
REQ-009 req_ready  out  1  queue not full; transfer when req_valid & req_ready.
REQ-010 pit_in_prefix  out  64  prefix presented to FIB.
REQ-011 pit_in_len  out  6  length presented to FIB.
REQ-012 fib_out_bit  out  1  one-cycle strobe: pit_in_prefix/len valid.
REQ-013 prefix_ready  in  1  FIB offers a returned data prefix.
REQ-014 pit_out_prefix  in  64  returned prefix.
REQ-015 pit_out_len  in  6  returned length.
REQ-016 out_data  in  8  FIB payload byte stream.
REQ-017 start_send_to_pit  out  1  one-cycle pulse: accept, FIB starts payload.
REQ-018 rejected  out  1  one-cycle pulse: returned prefix refused.
REQ-019 data_out  out  8  payload byte to local logic; data_valid  out  1; data_last  out  1.
REQ-020 reject_cnt  out  8  saturating count of rejected pulses.

Function
REQ-021 Tx: accepted requests SHALL enter a FIFO; req_ready low when QDEPTH entries held.
REQ-022 Tx: queue head SHALL issue only if a pending slot is free; issue drives pit_in_prefix/len and fib_out_bit high one cycle, writes head into lowest free pending slot, pops head.
REQ-023 Tx: at least one idle cycle SHALL separate consecutive fib_out_bit pulses; pit_in_prefix/len hold last issued value otherwise.
REQ-024 Tx: head whose prefix and len exactly match a valid pending entry SHALL be popped without fib_out_bit and without a new slot (interest aggregation), one cycle.
REQ-025 Rx FSM states R_IDLE, R_DECIDE, R_RECV.
REQ-026 R_IDLE: prefix_ready high at edge N latches pit_out_prefix/len, goes R_DECIDE.
REQ-027 R_DECIDE: exact match (prefix and len) against valid pending entries; at edge N+1 match -> start_send_to_pit high one cycle, go R_RECV; no match -> rejected high one cycle, reject_cnt +1 (saturate 255), go R_IDLE.
REQ-028 R_RECV: out_data SHALL be sampled on the PAYLOAD_BYTES edges after the start_send_to_pit cycle; each byte appears on data_out with data_valid one cycle later; data_last with the final byte.
REQ-029 On last byte sample, matched pending entry SHALL be invalidated and FSM returns to R_IDLE; prefix_ready ignored outside R_IDLE.
REQ-030 Slot freed and Tx insert in same cycle: insert uses a slot free before that edge; freed slot usable next cycle.
REQ-031 Simultaneous enqueue and issue on a full queue: req_ready stays low that cycle (no bypass).

Reset
REQ-032 rst high SHALL immediately clear FIFO, pending table, FSM to R_IDLE, reject_cnt to 0, and all outputs to 0 except req_ready=1 (while rst high, req_ready=0).
REQ-033 rst mid-receive SHALL abort the payload with no data_last; no further strobes until rst low.

Verification
REQ-034 Enqueue 64'h0000FFFF0000FFFF len 48 -> one fib_out_bit pulse with that prefix/len, pending slot 0 valid.
REQ-035 Then prefix_ready with same prefix/len, out_data 8'h11,22,33,44 -> start_send_to_pit at N+1, data_out 11,22,33,44, data_last on 44, slot 0 freed.
REQ-036 prefix_ready with 64'h1234 len 16, nothing pending -> rejected one cycle, reject_cnt=1, no start_send_to_pit.
REQ-037 Enqueue same prefix twice -> exactly one fib_out_bit; 5 distinct with PDEPTH 4 -> 4 pulses, 5th waits until a receive completes.
REQ-038 Enqueue 4 with pending full, 5th req_valid -> req_ready=0; rst asserted mid-R_RECV -> all outputs 0 immediately, reject_cnt=0.

Source files
------------

// File: rtl/pit_fib_port.sv
// PIT-to-FIB port: queues outgoing interests, tracks pending entries,
// and validates returned prefixes before streaming the payload bytes.
module pit_fib_port #(
  parameter int QDEPTH        = 4,
  parameter int PDEPTH        = 4,
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [63:0] req_prefix,
  input  logic [5:0]  req_len,
  output logic        req_ready,
  output logic [63:0] pit_in_prefix,
  output logic [5:0]  pit_in_len,
  output logic        fib_out_bit,
  input  logic        prefix_ready,
  input  logic [63:0] pit_out_prefix,
  input  logic [5:0]  pit_out_len,
  input  logic [7:0]  out_data,
  output logic        start_send_to_pit,
  output logic        rejected,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        data_last,
  output logic [7:0]  reject_cnt
);

  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = (PDEPTH > 1) ? $clog2(PDEPTH) : 1;
  localparam int BW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DECIDE,
    R_RECV
  } rx_state_t;

  logic [63:0]      q_prefix [QDEPTH];
  logic [5:0]       q_len    [QDEPTH];
  logic [QW-1:0]    wr_ptr;
  logic [QW-1:0]    rd_ptr;
  logic [CW-1:0]    q_count;
  logic             q_empty;
  logic             q_full;
  logic             push;
  logic             pop;
  logic             issue;
  logic [63:0]      head_prefix;
  logic [5:0]       head_len;

  logic [63:0]      p_prefix [PDEPTH];
  logic [5:0]       p_len    [PDEPTH];
  logic [PDEPTH-1:0] p_valid;
  logic             head_hit;
  logic             free_ok;
  logic [SW-1:0]    free_idx;

  rx_state_t        state;
  rx_state_t        state_nx;
  logic [63:0]      rx_prefix;
  logic [5:0]       rx_len;
  logic             rx_hit;
  logic [SW-1:0]    rx_idx;
  logic [SW-1:0]    m_idx;
  logic [BW-1:0]    bcnt;
  logic             last_byte;
  logic             start_d;
  logic             rej_d;
  logic             sample;
  logic             free_d;

  function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
    return (p == QW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_empty     = (q_count == '0);
  assign q_full      = (q_count == CW'(QDEPTH));
  assign req_ready   = ~rst & ~q_full;
  assign push        = req_valid & req_ready;
  assign head_prefix = q_prefix[rd_ptr];
  assign head_len    = q_len[rd_ptr];

  // Downward scan so the lowest free slot wins.
  always_comb begin
    head_hit = 1'b0;
    free_ok  = 1'b0;
    free_idx = '0;
    rx_hit   = 1'b0;
    rx_idx   = '0;
    for (int i = PDEPTH - 1; i >= 0; i--) begin
      if (!p_valid[i]) begin
        free_ok  = 1'b1;
        free_idx = SW'(i);
      end
      if (p_valid[i] && p_prefix[i] == head_prefix && p_len[i] == head_len)
        head_hit = 1'b1;
      if (p_valid[i] && p_prefix[i] == rx_prefix && p_len[i] == rx_len) begin
        rx_hit = 1'b1;
        rx_idx = SW'(i);
      end
    end
  end

  assign issue = ~q_empty & ~head_hit & free_ok & ~fib_out_bit;
  assign pop   = ~q_empty & (head_hit | issue);

  always_ff @(posedge clk) begin
    if (push) begin
      q_prefix[wr_ptr] <= req_prefix;
      q_len[wr_ptr]    <= req_len;
    end
    if (issue) begin
      p_prefix[free_idx] <= head_prefix;
      p_len[free_idx]    <= head_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      q_count       <= '0;
      p_valid       <= '0;
      fib_out_bit   <= 1'b0;
      pit_in_prefix <= '0;
      pit_in_len    <= '0;
    end else begin
      if (push) wr_ptr <= q_next(wr_ptr);
      if (pop)  rd_ptr <= q_next(rd_ptr);
      if (push && !pop)      q_count <= q_count + 1'b1;
      else if (!push && pop) q_count <= q_count - 1'b1;
      fib_out_bit <= issue;
      if (issue) begin
        pit_in_prefix     <= head_prefix;
        pit_in_len        <= head_len;
        p_valid[free_idx] <= 1'b1;
      end
      if (free_d) p_valid[m_idx] <= 1'b0;
    end
  end

  assign last_byte = (bcnt == BW'(PAYLOAD_BYTES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= R_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      R_IDLE:   if (prefix_ready) state_nx = R_DECIDE;
      R_DECIDE: state_nx = rx_hit ? R_RECV : R_IDLE;
      R_RECV:   if (last_byte) state_nx = R_IDLE;
      default:  state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    start_d = (state == R_DECIDE) & rx_hit;
    rej_d   = (state == R_DECIDE) & ~rx_hit;
    sample  = (state == R_RECV);
    free_d  = sample & last_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prefix         <= '0;
      rx_len            <= '0;
      m_idx             <= '0;
      bcnt              <= '0;
      start_send_to_pit <= 1'b0;
      rejected          <= 1'b0;
      reject_cnt        <= '0;
      data_out          <= '0;
      data_valid        <= 1'b0;
      data_last         <= 1'b0;
    end else begin
      if (state == R_IDLE && prefix_ready) begin
        rx_prefix <= pit_out_prefix;
        rx_len    <= pit_out_len;
      end
      if (state == R_DECIDE) begin
        m_idx <= rx_idx;
        bcnt  <= '0;
      end
      if (sample) begin
        bcnt     <= bcnt + 1'b1;
        data_out <= out_data;
      end
      start_send_to_pit <= start_d;
      rejected          <= rej_d;
      data_valid        <= sample;
      data_last         <= free_d;
      if (rej_d && reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pit_fib_port.sv
// Bench for pit_fib_port: scoreboarded FIB strobes and payload bytes,
// a probe table for the receive path, plus reset/backpressure sequences.
module tb_pit_fib_port;

  logic        clk = 0;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_prefix;
  logic [5:0]  req_len;
  logic        req_ready;
  logic [63:0] pit_in_prefix;
  logic [5:0]  pit_in_len;
  logic        fib_out_bit;
  logic        prefix_ready;
  logic [63:0] pit_out_prefix;
  logic [5:0]  pit_out_len;
  logic [7:0]  out_data;
  logic        start_send_to_pit;
  logic        rejected;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_last;
  logic [7:0]  reject_cnt;

  pit_fib_port #(.QDEPTH(4), .PDEPTH(4), .PAYLOAD_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_prefix(req_prefix), .req_len(req_len),
    .req_ready(req_ready),
    .pit_in_prefix(pit_in_prefix), .pit_in_len(pit_in_len),
    .fib_out_bit(fib_out_bit),
    .prefix_ready(prefix_ready), .pit_out_prefix(pit_out_prefix),
    .pit_out_len(pit_out_len), .out_data(out_data),
    .start_send_to_pit(start_send_to_pit), .rejected(rejected),
    .data_out(data_out), .data_valid(data_valid), .data_last(data_last),
    .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] p; logic [5:0] l; } fib_t;
  typedef struct { logic [7:0] b; logic last; } byte_t;
  typedef struct {
    bit          pre_enq;
    logic [63:0] prefix;
    logic [5:0]  len;
    bit          acc;
    logic [7:0]  cnt;
  } vec_t;

  fib_t  fibq[$];
  byte_t dq[$];
  int    asserts = 0;
  int    fails = 0;
  int    pulses = 0;
  logic  prev_fib = 0;
  vec_t  vt[6];
  localparam logic [63:0] PA = 64'h0000FFFF0000FFFF;
  localparam logic [63:0] PB = 64'hDEADBEEF00000000;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    fib_t  f;
    byte_t e;
    if (fib_out_bit) begin
      pulses++;
      chk("fib_gap", 64'(prev_fib), 64'd0);
      if (fibq.size() == 0) begin
        chk("fib_unexpected", 64'(pit_in_prefix), 64'hX);
      end else begin
        f = fibq.pop_front();
        chk("fib_prefix", pit_in_prefix, f.p);
        chk("fib_len", 64'(pit_in_len), 64'(f.l));
      end
    end
    prev_fib = fib_out_bit;
    if (data_valid) begin
      if (dq.size() == 0) begin
        chk("data_unexpected", 64'(data_out), 64'hX);
      end else begin
        e = dq.pop_front();
        chk("data_byte", 64'(data_out), 64'(e.b));
        chk("data_last", 64'(data_last), 64'(e.last));
      end
    end
  end

  task automatic enq(input logic [63:0] p, input logic [5:0] l,
                     input bit exp_pulse);
    int n = 0;
    fib_t f;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    if (!req_ready) chk("enq_timeout", 64'(req_ready), 64'd1);
    req_valid = 1; req_prefix = p; req_len = l;
    if (exp_pulse) begin
      f.p = p; f.l = l;
      fibq.push_back(f);
    end
    step();
    req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (fibq.size() != 0 && n < 60) begin
      step();
      n++;
    end
    chk("fib_drain", 64'(fibq.size()), 64'd0);
  endtask

  task automatic probe(input logic [63:0] p, input logic [5:0] l,
                       input bit acc, input logic [7:0] cnt);
    byte_t e;
    prefix_ready = 1; pit_out_prefix = p; pit_out_len = l;
    step();
    prefix_ready = 0;
    step();
    chk("start_send", 64'(start_send_to_pit), 64'(acc));
    chk("rejected", 64'(rejected), 64'(!acc));
    chk("reject_cnt", 64'(reject_cnt), 64'(cnt));
    if (acc) begin
      for (int b = 0; b < 4; b++) begin
        e.b = 8'($urandom);
        e.last = (b == 3);
        out_data = e.b;
        dq.push_back(e);
        step();
      end
      step();
    end else begin
      step();
      chk("reject_pulse", 64'(rejected), 64'd0);
    end
    chk("start_idle", 64'(start_send_to_pit), 64'd0);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_fib"}, 64'(fib_out_bit), 64'd0);
    chk({tag, "_pfx"}, pit_in_prefix, 64'd0);
    chk({tag, "_len"}, 64'(pit_in_len), 64'd0);
    chk({tag, "_start"}, 64'(start_send_to_pit), 64'd0);
    chk({tag, "_rej"}, 64'(rejected), 64'd0);
    chk({tag, "_dout"}, 64'(data_out), 64'd0);
    chk({tag, "_dv"}, 64'(data_valid), 64'd0);
    chk({tag, "_dl"}, 64'(data_last), 64'd0);
    chk({tag, "_cnt"}, 64'(reject_cnt), 64'd0);
    chk({tag, "_rdy"}, 64'(req_ready), 64'd0);
  endtask

  initial begin
    byte_t e;
    int n0;
    vt[0] = '{0, 64'h1234, 6'd16, 0, 8'd1};
    vt[1] = '{1, PA, 6'd48, 1, 8'd1};
    vt[2] = '{0, PA, 6'd48, 0, 8'd2};
    vt[3] = '{1, PB, 6'd32, 0, 8'd3};
    vt[4] = '{0, PB, 6'd32, 1, 8'd3};
    vt[5] = '{1, 64'hCAFE, 6'd0, 1, 8'd3};

    rst = 1; req_valid = 0; req_prefix = 0; req_len = 0;
    prefix_ready = 0; pit_out_prefix = 0; pit_out_len = 0; out_data = 0;
    #1;
    chk_zero_outs("rst0");
    repeat (3) step();
    rst = 0;
    step();
    chk("rdy_after_rst", 64'(req_ready), 64'd1);

    // Receive-path table; entry 3 queues PB/32 but probes PB/31.
    for (int i = 0; i < 6; i++) begin
      if (vt[i].pre_enq) begin
        enq(vt[i].prefix, vt[i].len, 1);
        drain();
        step();
      end
      if (i == 3) probe(PB, 6'd31, 0, vt[i].cnt);
      else        probe(vt[i].prefix, vt[i].len, vt[i].acc, vt[i].cnt);
    end

    // Pending full, FIFO full, then reset in the middle of a payload.
    for (int i = 0; i < 4; i++) enq(64'h100 + 64'(i), 6'd8, 1);
    drain();
    for (int i = 0; i < 4; i++) enq(64'h200 + 64'(i), 6'd8, 0);
    repeat (4) step();
    req_valid = 1; req_prefix = 64'h300; req_len = 6'd8;
    #1;
    chk("full_rdy", 64'(req_ready), 64'd0);
    step();
    req_valid = 0;
    prefix_ready = 1; pit_out_prefix = 64'h101; pit_out_len = 6'd8;
    step();
    prefix_ready = 0;
    step();
    chk("mid_start", 64'(start_send_to_pit), 64'd1);
    for (int b = 0; b < 2; b++) begin
      e.b = 8'hA0 + 8'(b); e.last = 0;
      out_data = e.b;
      dq.push_back(e);
      step();
    end
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    chk_zero_outs("rst_mid");
    repeat (3) step();
    chk("rst_hold_dv", 64'(data_valid), 64'd0);
    fibq.delete();
    rst = 0;
    step();
    chk("rdy_rel", 64'(req_ready), 64'd1);
    chk("cnt_rel", 64'(reject_cnt), 64'd0);

    // Five distinct interests: fifth waits for a freed slot.
    for (int i = 0; i < 5; i++) enq(64'h400 + 64'(i), 6'd20, 1);
    repeat (20) step();
    chk("fifth_waits", 64'(fibq.size()), 64'd1);
    probe(64'h401, 6'd20, 1, 8'd0);
    drain();
    // Aggregation: already-pending and duplicate interests.
    n0 = pulses;
    enq(64'h403, 6'd20, 0);
    repeat (6) step();
    chk("agg_pending", 64'(pulses), 64'(n0));
    probe(64'h400, 6'd20, 1, 8'd0);
    enq(64'h777, 6'd40, 1);
    enq(64'h777, 6'd40, 0);
    repeat (10) step();
    chk("dup_pulses", 64'(pulses), 64'(n0 + 1));
    chk("dup_drain", 64'(fibq.size()), 64'd0);
    probe(64'h777, 6'd40, 1, 8'd0);
    probe(64'h777, 6'd40, 0, 8'd1);

    repeat (3) step();
    chk("data_q_empty", 64'(dq.size()), 64'd0);
    chk("fib_q_empty", 64'(fibq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
